// File: rtl/eight_bit_restoring_divider.sv
// eight_bit_restoring_divider
//   Multi-cycle unsigned restoring divider with valid/ready handshakes on
//   both the operand and result sides. One quotient bit is produced per
//   clock, MSB first, so a division takes WIDTH cycles in BUSY.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : dividend/divisor presented
//   in_ready   : high only in IDLE, block can accept an operand pair
//   dividend   : unsigned numerator
//   divisor    : unsigned denominator
//   out_valid  : high only in DONE, result available
//   out_ready  : consumer takes the result
//   quotient   : floor(dividend / divisor), 8'hFF when divisor is zero
//   remainder  : dividend mod divisor, dividend when divisor is zero
//   div_zero   : divisor was zero (meaningful only with out_valid)
//
// Build option
//   DIV_ZERO_DETECT_EN : when defined, a zero divisor skips BUSY and the
//   result is presented right after the accepting edge with div_zero=1.
//   When undefined, div_zero is tied low and a zero divisor runs through
//   the normal iterative path, which naturally yields 8'hFF / dividend.

module eight_bit_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   dvnd;
  logic [WIDTH-1:0]   dvsr;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               q_bit;

  // One restoring step: bring in the next dividend bit, trial-subtract the
  // divisor in WIDTH+1 bits, and keep the difference only when it did not
  // go negative (borrow bit clear).
  always_comb begin
    trial = {remainder, dvnd[WIDTH-1]};
    diff  = trial - {1'b0, dvsr};
    q_bit = ~diff[WIDTH];
  end

  // Control FSM and datapath registers. The remainder output register
  // doubles as the partial remainder and the quotient output register
  // shifts in one bit per step, so both are final when DONE is entered
  // and stay untouched until the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvnd      <= '0;
      dvsr      <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvnd      <= dividend;
            dvsr      <= divisor;
            remainder <= '0;
            quotient  <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            state     <= BUSY;
`ifdef DIV_ZERO_DETECT_EN
            // Zero divisor: present the natural restoring result at once.
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`endif
          end
        end

        BUSY: begin
          dvnd      <= dvnd << 1;
          quotient  <= {quotient[WIDTH-2:0], q_bit};
          remainder <= q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          count     <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  // Zero-divisor flag, captured at acceptance and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_zero <= 1'b0;
    end else if (state == IDLE && in_valid && in_ready) begin
      div_zero <= (divisor == '0);
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule
